// File: rtl/pipelined_rca_adder_if.sv
// Operand/result bundle for pipelined_rca_adder.
// Handshake: a beat moves on a rising edge only when its valid and ready are
// both high (in_valid/in_ready upstream, out_valid/out_ready downstream).
// A producer holding valid high keeps its payload stable until the transfer;
// ready may depend on the consumer's state but never on the same-side valid.
interface pipelined_rca_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor. The operands are cut into STAGES
// slices of SW bits; each stage ripples one slice and registers its carry.
// Unprocessed operand bits and finished sum bits travel with the valid bit,
// so the last stage register holds the complete result. WIDTH must be a
// multiple of STAGES.
module pipelined_rca_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_rca_adder_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  // Whole pipeline advances or holds together.
  logic advance;

  // Stage registers: operand A, B' (already inverted for subtract),
  // partial sum, carry out of the slice, valid and signed overflow.
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] s_q     [STAGES];
  logic             c_q     [STAGES];
  logic             ovf_q   [STAGES];

  // Inputs seen by each stage: stage 0 from the bus, stage k from register k-1.
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];

  // Next values for each stage register.
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_d [STAGES];

  // Ripple scratch variables for the slice being evaluated.
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             c_msb;

  assign advance = !valid_q[STAGES-1] || bus.out_ready;

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.overflow  = ovf_q[STAGES-1];

  // Select each stage's source: fresh operands for stage 0, previous stage otherwise.
  always_comb begin
    src_a[0] = bus.a;
    src_b[0] = bus.sub ? ~bus.b : bus.b;
    src_s[0] = '0;
    src_c[0] = bus.sub ? 1'b1 : bus.cin;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  // Ripple slice k of each stage; the carry into the top bit is kept for overflow.
  always_comb begin
    acc   = '0;
    carry = 1'b0;
    c_msb = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      acc   = src_s[k];
      carry = src_c[k];
      c_msb = carry;
      for (int j = 0; j < SW; j++) begin
        c_msb = carry;
        acc[k*SW+j] = src_a[k][k*SW+j] ^ src_b[k][k*SW+j] ^ carry;
        carry = (src_a[k][k*SW+j] & src_b[k][k*SW+j]) |
                (carry & (src_a[k][k*SW+j] ^ src_b[k][k*SW+j]));
      end
      a_d[k]   = src_a[k];
      b_d[k]   = src_b[k];
      s_d[k]   = acc;
      c_d[k]   = carry;
      ovf_d[k] = c_msb ^ carry;
    end
  end

  // Stage registers: cleared by reset, loaded together on advance, held on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        s_q[k]     <= '0;
        c_q[k]     <= 1'b0;
        ovf_q[k]   <= 1'b0;
      end
    end else if (advance) begin
      valid_q[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
        ovf_q[k] <= ovf_d[k];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Bench for pipelined_rca_adder (WIDTH=16, STAGES=4). Inputs change on the
// falling edge, everything is sampled 2 ns later, well clear of the rising edge.
module tb_pipelined_rca_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int RW     = WIDTH + 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   pops;
  logic [RW-1:0] exp_q[$];

  pipelined_rca_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_rca_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic cin, input logic sub);
    int ua, ub, sa, sb, us, ss;
    logic c, ov;
    logic [31:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      us = ua - ub;
      ss = sa - sb;
      c  = (ua >= ub);
    end else begin
      us = ua + ub + int'(cin);
      ss = sa + sb + int'(cin);
      c  = (us >= (1 << WIDTH));
    end
    ov = (ss > (1 << (WIDTH-1)) - 1) || (ss < -(1 << (WIDTH-1)));
    r  = us;
    return {r[WIDTH-1:0], c, ov};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic cin, input logic sub, output bit acc);
    @(negedge clk);
    bus.in_valid = v;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.sub = sub;
    #2;
    acc = v && bus.in_ready;
    @(posedge clk);
    if (acc) exp_q.push_back(model(a, b, cin, sub));
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    bit acc;
    acc = 0;
    for (int t = 0; t < 200 && !acc; t++) drive_cycle(1'b1, a, b, cin, sub, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL issue_accept act=0 exp=1");
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  // Checks the spacing from acceptance to out_valid (call right after issue).
  task automatic latency_check(input string name, input logic [WIDTH-1:0] exp_sum);
    for (int k = 0; k < STAGES - 1; k++) begin
      @(negedge clk);
      #2;
      chk({name, "_early"}, bus.out_valid, 0);
    end
    @(negedge clk);
    #2;
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_sum"}, bus.sum, exp_sum);
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return WIDTH'($urandom());
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [RW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output act=%0h exp=none", bus.sum);
        end else begin
          e = exp_q.pop_front();
          pops++;
          chk("result", {bus.sum, bus.cout, bus.overflow}, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    bit acc, found, done;
    logic [WIDTH-1:0] held;
    bit pat [10];
    bit log_v [10];
    int pops0;

    checks = 0;
    errors = 0;
    pops = 0;
    bus.in_valid = 0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 0;
    bus.sub = 0;
    bus.out_ready = 1;
    rst_n = 0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Latency and basic add.
    issue(16'h00FF, 16'h0001, 0, 0);
    latency_check("lat", 16'h0100);
    chk("lat_cout", bus.cout, 0);
    chk("lat_ovf", bus.overflow, 0);
    wait_drain();

    // Boundary vectors.
    issue(16'hFFFF, 16'h0001, 0, 0);
    issue(16'h7FFF, 16'h0000, 1, 0);
    issue(16'h0005, 16'h0007, 0, 1);
    issue(16'h8000, 16'h0001, 0, 1);
    issue(16'h1234, 16'h8000, 1, 1);
    wait_drain();

    // Backpressure: 8 ops back to back, stall 3 cycles at first result.
    pops0 = pops;
    found = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) issue(WIDTH'(i), 16'h1000, 0, 0);
      end
      begin
        for (int t = 0; t < 50 && !found; t++) begin
          @(negedge clk);
          found = bus.out_valid;
        end
        if (!found) begin
          checks++;
          errors++;
          $display("FAIL bp_first_result act=0 exp=1");
        end
        bus.out_ready = 0;
        #2;
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_first_sum", bus.sum, 16'h1000);
        held = bus.sum;
        repeat (2) begin
          @(negedge clk);
          #2;
          chk("bp_in_ready_hold", bus.in_ready, 0);
          chk("bp_valid_hold", bus.out_valid, 1);
          chk("bp_sum_hold", bus.sum, held);
        end
        @(negedge clk);
        bus.out_ready = 1;
      end
    join
    wait_drain();
    chk("bp_count", pops - pops0, 8);

    // Bubbles: out_valid pattern should repeat in_valid pattern 4 cycles later.
    for (int i = 0; i < 10; i++) pat[i] = 0;
    pat[0] = 1; pat[2] = 1; pat[3] = 1;
    fork
      begin
        for (int i = 0; i < 10; i++)
          drive_cycle(pat[i], WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 0, acc);
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          #2;
          log_v[c] = bus.out_valid;
        end
      end
    join
    for (int c = 0; c < 10; c++)
      chk("bubble_valid", log_v[c], (c >= STAGES) ? pat[c-STAGES] : 1'b0);
    wait_drain();

    // Random traffic with random backpressure and gaps.
    done = 0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) drive_cycle(0, '0, '0, 0, 0, acc);
          issue(pick_operand(), pick_operand(), 1'($urandom()), 1'($urandom()));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    bus.out_ready = 1;
    wait_drain();

    // Reset mid-flight: three ops in the pipe are discarded.
    issue(16'h0101, 16'h0202, 0, 0);
    issue(16'h0303, 16'h0404, 0, 0);
    issue(16'h0505, 16'h0606, 1, 0);
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_sum", bus.sum, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #2;
      chk("post_rst_idle", bus.out_valid, 0);
    end
    issue(16'h1234, 16'h1111, 1, 0);
    latency_check("post_rst", 16'h2346);
    wait_drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; next generation of the team's fixed 4-bit ripple-carry adder.
- WIDTH-bit operands are split into STAGES equal slices. Each slice is a ripple-carry chain of full adders.
- The carry is registered between slices, so throughput is one operation per clock at latency STAGES.
- Adds add/subtract mode, a signed-overflow flag and a valid/ready handshake with backpressure. Sits in datapath blocks needing wide adds at high clock rates.

Parameters:
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline slices (1..WIDTH); slice width SW = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand presented this cycle.
- in_ready  output  1  block accepts operand this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out of MSB; in subtract mode 1 = no borrow (a >= b unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All stage valid bits clear; out_valid=0, sum=0, cout=0, overflow=0.
  - in_ready=1 combinationally after reset since pipeline is empty.
  - Reset mid-operation discards every in-flight operation; no result emerges for it.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Advance/stall:
  - advance = !out_valid || out_ready; in_ready = advance.
  - Global stall: when advance=0 every stage register holds, including data, carry and valid.
  - While stalled, in_valid and operands are ignored (not captured).
- Stage k (0..STAGES-1):
  - Adds slice k of a and b' (b' = sub ? ~b : b) with the incoming carry.
  - Stage 0 carry-in = sub ? 1 : cin.
  - Stage k>0 carry-in = registered carry-out of stage k-1.
- Operand skew:
  - Unused upper slices of a and b' ride a delay line alongside the valid bit.
  - Already-computed lower sum slices ride forward too; the final register holds the full WIDTH result.
- Timing:
  - Latency: operand captured at edge N produces out_valid=1 with its result after edge N+STAGES-1 (STAGES registers).
  - STAGES=1 gives a single registered full-width ripple adder with 1-cycle latency.
- Throughput: one result per cycle when out_ready held high; bubbles (in_valid=0) propagate as valid=0 slots.
- Output hold: out_valid, sum, cout, overflow stay stable while out_valid=1 and out_ready=0.
- Simultaneous output and input transfer in the same cycle is legal; the pipeline advances by one.
- Ordering: results emerge strictly in input order; none dropped or duplicated under any stall pattern.
- overflow is computed in the final stage from the MSB carry-in and carry-out and registered with sum.
- No combinational path from a/b to outputs. in_ready depends combinationally on out_ready and out_valid only.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: a=0x00FF, b=0x0001, cin=0, sub=0 -> after 4 edges out_valid=1, sum=0x0100, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, overflow=1.
- sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, overflow=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, overflow=1.
- Backpressure:
  - Stimulus: 8 back-to-back ops a=i, b=0x1000 (i=0..7); out_ready low for 3 cycles once first result appears.
  - Response: in_ready=0 during stall, held output unchanged; all 8 results 0x1000+i in order, none lost or duplicated.
- Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid pattern identical, delayed 4 cycles.
- Reset mid-flight: 3 ops in pipeline, assert rst_n=0 between edges -> outputs 0 immediately. After release, no stale results; next op returns correct sum at latency 4.
